// File: rtl/pipes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipes_pkg
// Brief   : Shared pipeline types and helpers (memory arbiter request, ID sizing)
// Revision: 1.0 - initial memory-arbiter additions
// ============================================================================
package pipes_pkg;

    localparam int ARB_PA_WIDTH   = 32;
    localparam int ARB_LINE_WIDTH = 128;

    typedef struct packed {
        logic                      write;
        logic [ARB_PA_WIDTH-1:0]   addr;
        logic [ARB_LINE_WIDTH-1:0] data;
    } arb_req_t;

    // A single channel still needs one bit of channel field in the ID.
    function automatic int arb_ch_bits(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int arb_id_width(input int num_ch, input int seq_bits);
        return arb_ch_bits(num_ch) + seq_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Rotating-priority picker; first eligible index at or above i_ptr
// Revision: 1.0 - initial
// ============================================================================
module rr_pick
    import pipes_pkg::*;
#(
    parameter  int N     = 2,
    localparam int PTR_W = arb_ch_bits(N)
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    localparam int C_SUM_W = PTR_W + 1;

    logic [C_SUM_W-1:0] w_cand;

    // Candidate index is (i_ptr + k) mod N; one extra bit avoids overflow.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, i_ptr} + C_SUM_W'(k);
            if (w_cand >= C_SUM_W'(N)) begin
                w_cand = w_cand - C_SUM_W'(N);
            end
            if (!o_valid && i_eligible[w_cand[PTR_W-1:0]]) begin
                o_valid                    = 1'b1;
                o_idx                      = w_cand[PTR_W-1:0];
                o_grant[w_cand[PTR_W-1:0]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_rr
// Brief   : N-channel memory request arbiter with read credits and ID routing
// Revision: 1.0 - initial
// ============================================================================
module mem_arbiter_rr
    import pipes_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int PA_WIDTH   = 32,
    parameter  int LINE_WIDTH = 128,
    parameter  int SEQ_BITS   = 2,
    parameter  int MAX_OUT    = 2,
    parameter  int FIXED_PRIO = 0,
    localparam int ID_WIDTH   = arb_id_width(NUM_CH, SEQ_BITS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            i_req_valid,
    input  logic [NUM_CH-1:0]            i_req_write,
    input  logic [NUM_CH*PA_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_CH*LINE_WIDTH-1:0] i_req_data,
    output logic [NUM_CH-1:0]            o_req_grant,
    output logic [ID_WIDTH-1:0]          o_req_id,
    input  logic                         i_mem_full,
    output logic                         o_mem_enable,
    output logic                         o_mem_write,
    output logic [PA_WIDTH-1:0]          o_mem_addr,
    output logic [LINE_WIDTH-1:0]        o_mem_data,
    output logic [ID_WIDTH-1:0]          o_mem_id,
    input  logic                         i_resp_enable,
    input  logic [ID_WIDTH-1:0]          i_resp_id,
    output logic [NUM_CH-1:0]            o_resp_hit,
    output logic                         o_err_bad_id
);

    localparam int C_CH_BITS = arb_ch_bits(NUM_CH);
    localparam int C_CNT_W   = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic                  write;
        logic [PA_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0] data;
    } req_t;

    logic [NUM_CH-1:0]    w_eligible;
    logic [NUM_CH-1:0]    w_grant;
    logic [NUM_CH-1:0]    w_read_grant;
    logic [NUM_CH-1:0]    w_dec;
    logic [NUM_CH-1:0]    w_cnt_nz;
    logic [C_CH_BITS-1:0] w_idx;
    logic [C_CH_BITS-1:0] w_pick_ptr;
    logic [C_CH_BITS-1:0] w_ptr_next;
    logic [C_CH_BITS-1:0] w_resp_ch;
    logic                 w_any;
    logic                 w_err;
    logic                 w_unused_seq;
    req_t                 w_sel;

    logic [C_CH_BITS-1:0] r_rr_ptr;
    logic [SEQ_BITS-1:0]  r_seq     [NUM_CH];
    logic [C_CNT_W-1:0]   r_out_cnt [NUM_CH];
    logic                 r_mem_enable;
    logic [ID_WIDTH-1:0]  r_mem_id;
    logic                 r_err_bad_id;
    req_t                 r_issue;

    assign w_resp_ch    = i_resp_id[ID_WIDTH-1:SEQ_BITS];
    assign w_unused_seq = ^i_resp_id[SEQ_BITS-1:0];

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_cnt_nz[c]     = (r_out_cnt[c] != '0);
            // Credit test uses the pre-response count; freed credit is usable next cycle.
            assign w_eligible[c]   = i_req_valid[c] && !i_mem_full &&
                                     (i_req_write[c] || (r_out_cnt[c] < C_CNT_W'(MAX_OUT)));
            assign o_resp_hit[c]   = i_resp_enable && (w_resp_ch == C_CH_BITS'(c));
            assign w_read_grant[c] = w_grant[c] && !i_req_write[c];
            assign w_dec[c]        = o_resp_hit[c] && w_cnt_nz[c];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_seq[c]     <= '0;
                    r_out_cnt[c] <= '0;
                end else begin
                    if (w_grant[c]) begin
                        r_seq[c] <= r_seq[c] + SEQ_BITS'(1);
                    end
                    if (w_read_grant[c] && !w_dec[c]) begin
                        r_out_cnt[c] <= r_out_cnt[c] + C_CNT_W'(1);
                    end else if (w_dec[c] && !w_read_grant[c]) begin
                        r_out_cnt[c] <= r_out_cnt[c] - C_CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Fixed priority is the rotating search pinned to start at channel 0.
    assign w_pick_ptr = (FIXED_PRIO != 0) ? '0 : r_rr_ptr;

    rr_pick #(
        .N (NUM_CH)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_ptr      (w_pick_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_idx),
        .o_valid    (w_any)
    );

    assign o_req_grant = w_grant;
    assign o_req_id    = w_any ? {w_idx, r_seq[w_idx]} : '0;
    assign w_ptr_next  = (w_idx == C_CH_BITS'(NUM_CH - 1)) ? '0 : w_idx + C_CH_BITS'(1);

    // Unroutable: illegal channel field, or the owner has nothing outstanding.
    assign w_err = i_resp_enable && !(|(o_resp_hit & w_cnt_nz));

    always_comb begin
        w_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) begin
                w_sel.write = i_req_write[c];
                w_sel.addr  = i_req_addr[c*PA_WIDTH +: PA_WIDTH];
                w_sel.data  = i_req_data[c*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_enable <= 1'b0;
            r_issue      <= '0;
            r_mem_id     <= '0;
            r_err_bad_id <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            r_mem_enable <= w_any;
            r_err_bad_id <= w_err;
            if (w_any) begin
                r_issue  <= w_sel;
                r_mem_id <= o_req_id;
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    assign o_mem_enable = r_mem_enable;
    assign o_mem_write  = r_issue.write;
    assign o_mem_addr   = r_issue.addr;
    assign o_mem_data   = r_issue.data;
    assign o_mem_id     = r_mem_id;
    assign o_err_bad_id = r_err_bad_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter_rr
// Brief   : Round-robin and fixed-priority arbiter instances against a reference model
// Revision: 1.0 - initial
// ============================================================================
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  req_valid, req_write;
    logic [47:0] req_addr;
    logic [95:0] req_data;
    logic        mem_full, resp_en;
    logic [3:0]  resp_id;

    logic [1:0][2:0]  grant, hit;
    logic [1:0][3:0]  req_id, mem_id;
    logic [1:0]       mem_en, mem_wr, err;
    logic [1:0][15:0] mem_addr;
    logic [1:0][31:0] mem_data;

    int checks   = 0;
    int failures = 0;

    // Instance 0: round robin, 2 credits. Instance 1: fixed priority, 4 credits.
    int m_max[2]   = '{2, 4};
    int m_fixed[2] = '{0, 1};

    int          ptr[2];
    int          seq[2][3];
    int          cnt[2][3];
    logic        e_en[2], e_wr[2], e_err[2];
    logic [15:0] e_addr[2];
    logic [31:0] e_data[2];
    logic [3:0]  e_id[2];

    logic [2:0] obs_grant[2], obs_hit[2];
    logic [3:0] obs_id[2], obs_mid[2];
    logic       obs_en[2], obs_err[2];

    mem_arbiter_rr #(
        .NUM_CH(3), .PA_WIDTH(16), .LINE_WIDTH(32), .SEQ_BITS(2), .MAX_OUT(2), .FIXED_PRIO(0)
    ) u_rr (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_grant(grant[0]), .o_req_id(req_id[0]), .i_mem_full(mem_full),
        .o_mem_enable(mem_en[0]), .o_mem_write(mem_wr[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_data(mem_data[0]), .o_mem_id(mem_id[0]),
        .i_resp_enable(resp_en), .i_resp_id(resp_id), .o_resp_hit(hit[0]), .o_err_bad_id(err[0])
    );

    mem_arbiter_rr #(
        .NUM_CH(3), .PA_WIDTH(16), .LINE_WIDTH(32), .SEQ_BITS(2), .MAX_OUT(4), .FIXED_PRIO(1)
    ) u_fp (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_grant(grant[1]), .o_req_id(req_id[1]), .i_mem_full(mem_full),
        .o_mem_enable(mem_en[1]), .o_mem_write(mem_wr[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_data(mem_data[1]), .o_mem_id(mem_id[1]),
        .i_resp_enable(resp_en), .i_resp_id(resp_id), .o_resp_hit(hit[1]), .o_err_bad_id(err[1])
    );

    task automatic drive_idle();
        req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
        mem_full = 1'b0; resp_en = 1'b0; resp_id = '0;
    endtask

    task automatic randomize_payload();
        req_addr = 48'({$urandom(), $urandom()});
        req_data = 96'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ptr[m] = 0;
            for (int c = 0; c < 3; c++) begin seq[m][c] = 0; cnt[m][c] = 0; end
            e_en[m] = 1'b0; e_wr[m] = 1'b0; e_err[m] = 1'b0;
            e_addr[m] = '0; e_data[m] = '0; e_id[m] = '0;
        end
    endtask

    // One cycle: inputs were driven just after the previous edge.
    task automatic step();
        int g, c, rch;
        logic [2:0] eg, eh;
        logic [3:0] eid;
        logic ee, dec;
        #1;
        for (int m = 0; m < 2; m++) begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                c = (m_fixed[m] != 0) ? k : (ptr[m] + k) % 3;
                if (g < 0 && req_valid[c] && !mem_full && (req_write[c] || cnt[m][c] < m_max[m])) g = c;
            end
            eg  = (g >= 0) ? 3'(1 << g) : 3'b000;
            eid = (g >= 0) ? 4'(g * 4 + seq[m][g]) : 4'h0;
            rch = int'(resp_id[3:2]);
            eh  = (resp_en && rch < 3) ? 3'(1 << rch) : 3'b000;
            ee  = resp_en && (rch >= 3 || cnt[m][rch] == 0);
            dec = resp_en && rch < 3 && cnt[m][rch] > 0;

            obs_grant[m] = grant[m]; obs_hit[m] = hit[m]; obs_id[m] = req_id[m];
            checks++; if (grant[m] !== eg) begin failures++; $display("FAIL grant[%0d] t=%0t got=%b exp=%b", m, $time, grant[m], eg); end
            checks++; if (req_id[m] !== eid) begin failures++; $display("FAIL req_id[%0d] t=%0t got=%h exp=%h", m, $time, req_id[m], eid); end
            checks++; if (hit[m] !== eh) begin failures++; $display("FAIL resp_hit[%0d] t=%0t got=%b exp=%b", m, $time, hit[m], eh); end

            e_en[m]  = (g >= 0);
            e_err[m] = ee;
            if (g >= 0) begin
                e_wr[m]   = req_write[g];
                e_addr[m] = req_addr[g*16 +: 16];
                e_data[m] = req_data[g*32 +: 32];
                e_id[m]   = eid;
                seq[m][g] = (seq[m][g] + 1) % 4;
                ptr[m]    = (g + 1) % 3;
                if (!req_write[g]) cnt[m][g]++;
            end
            if (dec) cnt[m][rch]--;
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            obs_en[m] = mem_en[m]; obs_err[m] = err[m]; obs_mid[m] = mem_id[m];
            checks++; if (mem_en[m] !== e_en[m]) begin failures++; $display("FAIL mem_enable[%0d] t=%0t got=%b exp=%b", m, $time, mem_en[m], e_en[m]); end
            checks++; if (mem_wr[m] !== e_wr[m]) begin failures++; $display("FAIL mem_write[%0d] t=%0t got=%b exp=%b", m, $time, mem_wr[m], e_wr[m]); end
            checks++; if (mem_addr[m] !== e_addr[m]) begin failures++; $display("FAIL mem_addr[%0d] t=%0t got=%h exp=%h", m, $time, mem_addr[m], e_addr[m]); end
            checks++; if (mem_data[m] !== e_data[m]) begin failures++; $display("FAIL mem_data[%0d] t=%0t got=%h exp=%h", m, $time, mem_data[m], e_data[m]); end
            checks++; if (mem_id[m] !== e_id[m]) begin failures++; $display("FAIL mem_id[%0d] t=%0t got=%h exp=%h", m, $time, mem_id[m], e_id[m]); end
            checks++; if (err[m] !== e_err[m]) begin failures++; $display("FAIL err_bad_id[%0d] t=%0t got=%b exp=%b", m, $time, err[m], e_err[m]); end
        end
    endtask

    // Asynchronous reset: registered outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if ({mem_en[m], mem_wr[m], err[m]} !== 3'b000) begin failures++; $display("FAIL reset_flags[%0d] got=%b exp=000", m, {mem_en[m], mem_wr[m], err[m]}); end
            checks++; if ({mem_addr[m], mem_data[m], mem_id[m]} !== 52'h0) begin failures++; $display("FAIL reset_issue[%0d] got=%h exp=0", m, {mem_addr[m], mem_data[m], mem_id[m]}); end
            checks++; if ({grant[m], req_id[m], hit[m]} !== 10'h0) begin failures++; $display("FAIL reset_comb[%0d] got=%h exp=0", m, {grant[m], req_id[m], hit[m]}); end
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        do_reset();
        step();
    endtask

    task automatic test_rr_fairness();
        int n0;
        do_reset();
        n0 = 0;
        req_valid = 3'b111; req_write = 3'b000;
        for (int i = 0; i < 15; i++) begin
            randomize_payload();
            resp_en = mem_en[0] && !mem_wr[0];
            resp_id = mem_id[0];
            step();
            checks++; if (obs_grant[0] !== 3'(1 << (i % 3))) begin failures++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", i, obs_grant[0], 3'(1 << (i % 3))); end
            checks++; if (obs_mid[0][3:2] !== 2'(i % 3)) begin failures++; $display("FAIL rr_mem_ch cyc=%0d got=%0d exp=%0d", i, obs_mid[0][3:2], i % 3); end
            if (i % 3 == 0) begin
                checks++; if (obs_id[0][1:0] !== 2'(n0 % 4)) begin failures++; $display("FAIL rr_seq ch0 n=%0d got=%0d exp=%0d", n0, obs_id[0][1:0], n0 % 4); end
                n0++;
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req_valid = 3'b101; req_write = 3'b101;
        for (int i = 0; i < 4; i++) begin
            randomize_payload();
            step();
            checks++; if (obs_grant[1] !== 3'b001) begin failures++; $display("FAIL fixed_ch0 cyc=%0d got=%b exp=001", i, obs_grant[1]); end
        end
        req_valid = 3'b100;
        step();
        checks++; if (obs_grant[1] !== 3'b100) begin failures++; $display("FAIL fixed_ch2 got=%b exp=100", obs_grant[1]); end
    endtask

    task automatic test_credit();
        logic [2:0] exp_g[8] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        do_reset();
        req_valid = 3'b010; req_write = 3'b000;
        for (int i = 0; i < 8; i++) begin
            randomize_payload();
            resp_en = (i == 5);
            resp_id = 4'b0100;
            step();
            checks++; if (obs_grant[0] !== exp_g[i]) begin failures++; $display("FAIL credit cyc=%0d got=%b exp=%b", i, obs_grant[0], exp_g[i]); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 3'b001; req_write = 3'b000;
        randomize_payload();
        step();
        resp_en = 1'b1; resp_id = 4'b0000;
        step();
        checks++; if (obs_grant[0] !== 3'b001 || obs_hit[0] !== 3'b001) begin failures++; $display("FAIL simul grant/hit got=%b/%b exp=001/001", obs_grant[0], obs_hit[0]); end
        checks++; if (obs_err[0] !== 1'b0) begin failures++; $display("FAIL simul err got=%b exp=0", obs_err[0]); end
        resp_en = 1'b0;
        step();
        checks++; if (obs_grant[0] !== 3'b001) begin failures++; $display("FAIL simul second got=%b exp=001", obs_grant[0]); end
        step();
        checks++; if (obs_grant[0] !== 3'b000) begin failures++; $display("FAIL simul limit got=%b exp=000", obs_grant[0]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 3'b001; req_write = 3'b001;
        step();
        req_valid = 3'b111; req_write = 3'b111; mem_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_payload();
            step();
            for (int m = 0; m < 2; m++) begin
                checks++; if (obs_grant[m] !== 3'b000 || obs_en[m] !== 1'b0) begin failures++; $display("FAIL full[%0d] cyc=%0d grant=%b en=%b exp=000/0", m, i, obs_grant[m], obs_en[m]); end
            end
        end
        mem_full = 1'b0;
        step();
        checks++; if (obs_grant[0] !== 3'b010) begin failures++; $display("FAIL release_rr got=%b exp=010", obs_grant[0]); end
        checks++; if (obs_grant[1] !== 3'b001) begin failures++; $display("FAIL release_fp got=%b exp=001", obs_grant[1]); end
    endtask

    task automatic test_bad_id();
        do_reset();
        resp_en = 1'b1; resp_id = 4'b1100;
        step();
        checks++; if (obs_hit[0] !== 3'b000 || obs_err[0] !== 1'b1) begin failures++; $display("FAIL bad_id hit/err got=%b/%b exp=000/1", obs_hit[0], obs_err[0]); end
        resp_en = 1'b0;
        step();
        checks++; if (obs_err[0] !== 1'b0) begin failures++; $display("FAIL bad_id pulse got=%b exp=0", obs_err[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 3'b111; req_write = 3'b000;
        for (int i = 0; i < 5; i++) begin
            randomize_payload();
            step();
        end
        do_reset();
        resp_en = 1'b1; resp_id = 4'b0100;
        step();
        checks++; if (obs_hit[0] !== 3'b010 || obs_err[0] !== 1'b1) begin failures++; $display("FAIL stale_id hit/err got=%b/%b exp=010/1", obs_hit[0], obs_err[0]); end
        resp_en = 1'b0;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = 3'($urandom());
            req_write = 3'($urandom());
            mem_full  = ($urandom_range(0, 4) == 0);
            randomize_payload();
            if (mem_en[0] && !mem_wr[0] && $urandom_range(0, 1) == 1) begin
                resp_en = 1'b1; resp_id = mem_id[0];
            end else begin
                resp_en = ($urandom_range(0, 3) == 0);
                resp_id = 4'($urandom());
            end
            step();
        end
        drive_idle();
        step();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_rr_fairness();
        test_fixed_prio();
        test_credit();
        test_simultaneous();
        test_backpressure();
        test_bad_id();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
